// File: rtl/lvt_scan_if.sv
// Serial pin bundle between a scan driver and lvt_scan_harness.
// sin is consumed on every cycle sin_vld is high; sout is meaningful only while sout_vld is high;
// done pulses for one cycle after the last sout bit; state mirrors the harness FSM for checkers.
interface lvt_scan_if;
  logic       sin;
  logic       sin_vld;
  logic       sout;
  logic       sout_vld;
  logic       busy;
  logic       done;
  logic       ovf;
  logic       perr;
  logic [1:0] state;

  modport master (
    output sin, sin_vld,
    input  sout, sout_vld, busy, done, ovf, perr, state
  );

  modport slave (
    input  sin, sin_vld,
    output sout, sout_vld, busy, done, ovf, perr, state
  );
endinterface

// File: rtl/lvt_scan_harness.sv
// Serial scan harness around a live-value-table multiport memory (lvt_memory, same file).
// Optional frame parity bit enabled by defining LVT_SCAN_PARITY_EN.

// Multiport RAM: one bank per write port, the LVT records which bank holds the live word.
module lvt_memory #(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 512,
  parameter int PORTS   = 2,
  parameter int MEM_LAT = 1,
  parameter int AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                         clk,
  input  logic [PORTS-1:0][AW-1:0]     addr,
  input  logic [PORTS-1:0]             en,
  input  logic [PORTS-1:0][WIDTH-1:0]  d,
  output logic [PORTS-1:0][WIDTH-1:0]  q
);
  localparam int LW = (PORTS > 1) ? $clog2(PORTS) : 1;

  logic [WIDTH-1:0]              bank    [PORTS][DEPTH];
  logic [LW-1:0]                 lvt     [DEPTH];
  logic [PORTS-1:0][WIDTH-1:0]   rd_pipe [MEM_LAT];

  always_ff @(posedge clk) begin
    for (int p = 0; p < PORTS; p++) begin
      if (en[p]) begin
        bank[p][addr[p]] <= d[p];
        lvt[addr[p]]     <= LW'(p);
      end
    end
    for (int r = 0; r < PORTS; r++) begin
      rd_pipe[0][r] <= bank[lvt[addr[r]]][addr[r]];
    end
    for (int s = 1; s < MEM_LAT; s++) begin
      rd_pipe[s] <= rd_pipe[s-1];
    end
  end

  assign q = rd_pipe[MEM_LAT-1];
endmodule

module lvt_scan_harness #(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 512,
  parameter int PORTS   = 2,
  parameter int MEM_LAT = 1
) (
  input  logic       clk,
  input  logic       rst,
  lvt_scan_if.slave  bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef LVT_SCAN_PARITY_EN
  localparam int PAR_W = 1;
`else
  localparam int PAR_W = 0;
`endif
  localparam int FRAME_W = PORTS * (AW + WIDTH + 1) + PAR_W;
  localparam int OUT_W   = PORTS * WIDTH;
  localparam int CNT_MAX = (FRAME_W > OUT_W) ? ((FRAME_W > MEM_LAT) ? FRAME_W : MEM_LAT)
                                             : ((OUT_W > MEM_LAT) ? OUT_W : MEM_LAT);
  localparam int CW = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_APPLY = 2'd1,
    S_WAIT  = 2'd2,
    S_SHIFT = 2'd3
  } state_t;

  state_t                       state_q;
  logic [CW-1:0]                cnt_q;
  logic [FRAME_W-1:0]           frame_q;
  logic [OUT_W-1:0]             sh_q;
  logic                         sout_q;
  logic                         sout_vld_q;
  logic                         busy_q;
  logic                         done_q;
  logic                         ovf_q;

  logic [PORTS-1:0][AW-1:0]     f_addr;
  logic [PORTS-1:0][WIDTH-1:0]  f_d;
  logic [PORTS-1:0]             f_en;
  logic [PORTS-1:0]             collide;
  logic [PORTS-1:0]             mem_en;
  logic [PORTS-1:0][WIDTH-1:0]  lvt_q;
  logic                         par_err;

  // Frame fields: {en, d[P-1..0], addr[P-1..0]}, port 0 in the LSBs of each field.
  always_comb begin
    f_addr = '0;
    f_d    = '0;
    for (int i = 0; i < PORTS; i++) begin
      f_addr[i] = frame_q[i*AW +: AW];
      f_d[i]    = frame_q[PORTS*AW + i*WIDTH +: WIDTH];
    end
    f_en = frame_q[PORTS*(AW+WIDTH) +: PORTS];
  end

  // A port loses its write when any higher-numbered enabled port targets the same word.
  always_comb begin
    collide = '0;
    for (int i = 0; i < PORTS; i++) begin
      for (int j = i + 1; j < PORTS; j++) begin
        if (f_en[j] && (f_addr[j] == f_addr[i])) begin
          collide[i] = 1'b1;
        end
      end
    end
  end

`ifdef LVT_SCAN_PARITY_EN
  // Even parity: the whole frame including the parity bit must XOR to zero.
  assign par_err = ^frame_q;
`else
  assign par_err = 1'b0;
`endif

  assign mem_en = ((state_q == S_APPLY) && !par_err) ? (f_en & ~collide) : '0;

  lvt_memory #(
    .WIDTH   (WIDTH),
    .DEPTH   (DEPTH),
    .PORTS   (PORTS),
    .MEM_LAT (MEM_LAT),
    .AW      (AW)
  ) u_mem (
    .clk  (clk),
    .addr (f_addr),
    .en   (mem_en),
    .d    (f_d),
    .q    (lvt_q)
  );

`ifdef LVT_SCAN_PARITY_EN
  logic perr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      perr_q <= 1'b0;
    end else if ((state_q == S_APPLY) && par_err) begin
      perr_q <= 1'b1;
    end
  end

  assign bus.perr = perr_q;
`else
  assign bus.perr = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      frame_q    <= '0;
      sh_q       <= '0;
      sout_q     <= 1'b0;
      sout_vld_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (bus.sin_vld && (state_q != S_IDLE)) begin
        ovf_q <= 1'b1;
      end
      case (state_q)
        S_IDLE: begin
          if (bus.sin_vld) begin
            frame_q <= {bus.sin, frame_q[FRAME_W-1:1]};
            if (cnt_q == CW'(FRAME_W - 1)) begin
              cnt_q   <= '0;
              state_q <= S_APPLY;
              busy_q  <= 1'b1;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
        end
        S_APPLY: begin
          cnt_q   <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          // The last WAIT edge is the one where q holds the APPLY-cycle read.
          if (cnt_q == CW'(MEM_LAT - 1)) begin
            sh_q       <= lvt_q >> 1;
            sout_q     <= lvt_q[0][0];
            sout_vld_q <= 1'b1;
            cnt_q      <= '0;
            state_q    <= S_SHIFT;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_SHIFT: begin
          if (cnt_q == CW'(OUT_W - 1)) begin
            sout_q     <= 1'b0;
            sout_vld_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
            cnt_q      <= '0;
            state_q    <= S_IDLE;
          end else begin
            sout_q <= sh_q[0];
            sh_q   <= sh_q >> 1;
            cnt_q  <= cnt_q + CW'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.sout     = sout_q;
  assign bus.sout_vld = sout_vld_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.ovf      = ovf_q;
  assign bus.state    = state_q;
endmodule

// File: tb/tb_lvt_scan_harness.sv
// Bench for lvt_scan_harness at WIDTH=8, DEPTH=16, PORTS=2, MEM_LAT=1.
// Read frames push the expected 16-bit readback; a negedge monitor pops and compares.
module tb_lvt_scan_harness;
  localparam int W   = 8;
  localparam int D   = 16;
  localparam int P   = 2;
  localparam int L   = 1;
  localparam int OW  = P * W;
`ifdef LVT_SCAN_PARITY_EN
  localparam int FW  = 27;
`else
  localparam int FW  = 26;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  lvt_scan_if bus ();

  lvt_scan_harness #(.WIDTH(W), .DEPTH(D), .PORTS(P), .MEM_LAT(L)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [W-1:0]  model [D];
  logic [OW-1:0] exp_q [$];
  bit            skip_q[$];
  logic [OW-1:0] acc;
  int            nb = 0;

  // Monitor: gathers OW sout bits (bit k in cycle k) and compares against the scoreboard.
  always @(negedge clk) begin
    logic [OW-1:0] e;
    bit            s;
    if (rst) begin
      nb = 0;
    end else if (bus.sout_vld) begin
      acc[nb] = bus.sout;
      nb++;
      if (nb == OW) begin
        nb = 0;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL readback_unexpected: got %h, no readback expected", acc);
        end else begin
          e = exp_q.pop_front();
          s = skip_q.pop_front();
          if (!s) begin
            checks++;
            if (acc !== e) begin
              errors++;
              $display("FAIL readback_data: got %h, expected %h", acc, e);
            end
          end
        end
      end
    end
  end

  task automatic send_frame(input logic [3:0] a0, input logic [3:0] a1,
                            input logic [W-1:0] d0, input logic [W-1:0] d1,
                            input logic [1:0] en, input int gap_max, input bit bad_par);
    logic [FW-1:0] f;
    f = '0;
    f[3:0]   = a0;
    f[7:4]   = a1;
    f[15:8]  = d0;
    f[23:16] = d1;
    f[25:24] = en;
`ifdef LVT_SCAN_PARITY_EN
    f[26] = (^f[25:0]) ^ bad_par;
`endif
    if (en == 2'b00) begin
      exp_q.push_back({model[a1], model[a0]});
      skip_q.push_back(1'b0);
    end else begin
      exp_q.push_back('0);
      skip_q.push_back(1'b1);
      if (!bad_par) begin
        if (en[0] && !(en[1] && (a1 == a0))) model[a0] = d0;
        if (en[1]) model[a1] = d1;
      end
    end
    for (int i = 0; i < FW; i++) begin
      repeat ($urandom_range(0, gap_max)) begin
        bus.sin_vld = 1'b0;
        @(posedge clk); #1;
      end
      bus.sin     = f[i];
      bus.sin_vld = 1'b1;
      @(posedge clk); #1;
    end
    bus.sin_vld = 1'b0;
    bus.sin     = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(posedge clk); #1;
      if (bus.done) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s_done_timeout: done=0, expected a done pulse within 200 cycles", name);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.sin = 1'b1;
    bus.sin_vld = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bus.sout, bus.sout_vld, bus.busy, bus.done} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_outputs: sout,vld,busy,done=%b, expected 0000",
               {bus.sout, bus.sout_vld, bus.busy, bus.done});
    end
    checks++;
    if ({bus.ovf, bus.perr} !== 2'b00) begin
      errors++;
      $display("FAIL reset_flags: ovf,perr=%b, expected 00", {bus.ovf, bus.perr});
    end
    checks++;
    if (bus.state !== 2'd0) begin
      errors++;
      $display("FAIL reset_state: state=%0d, expected 0", bus.state);
    end
    bus.sin_vld = 1'b0;
    bus.sin = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    bit vld_ok;
    send_frame(4'd3, 4'd7, 8'hA5, 8'h3C, 2'b11, 0, 1'b0);
    wait_done("write1");
    send_frame(4'd3, 4'd7, 8'h00, 8'h00, 2'b00, 0, 1'b0);
    checks++;
    if (bus.busy !== 1'b1 || bus.state !== 2'd1) begin
      errors++;
      $display("FAIL apply_entry: busy=%b state=%0d, expected busy=1 state=1", bus.busy, bus.state);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.sout_vld !== 1'b0) begin
      errors++;
      $display("FAIL latency_early: sout_vld=%b one edge after last bit, expected 0", bus.sout_vld);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.sout_vld !== 1'b1) begin
      errors++;
      $display("FAIL latency_first: sout_vld=%b two edges after last bit, expected 1", bus.sout_vld);
    end
    vld_ok = 1'b1;
    for (int i = 1; i < OW; i++) begin
      @(posedge clk); #1;
      if (bus.sout_vld !== 1'b1 || bus.done !== 1'b0) vld_ok = 1'b0;
    end
    checks++;
    if (!vld_ok) begin
      errors++;
      $display("FAIL sout_vld_window: window broken, expected %0d consecutive cycles", OW);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.sout_vld !== 1'b0 || bus.done !== 1'b1 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL done_pulse: vld=%b done=%b busy=%b, expected 0 1 0",
               bus.sout_vld, bus.done, bus.busy);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.done !== 1'b0) begin
      errors++;
      $display("FAIL done_width: done=%b a cycle later, expected 0", bus.done);
    end
  endtask

  task automatic test_collision();
    send_frame(4'd5, 4'd5, 8'h22, 8'h11, 2'b11, 0, 1'b0);
    wait_done("collide_wr");
    send_frame(4'd5, 4'd5, 8'h00, 8'h00, 2'b00, 0, 1'b0);
    wait_done("collide_rd");
    send_frame(4'd5, 4'd3, 8'h00, 8'h00, 2'b00, 0, 1'b0);
    wait_done("collide_rd2");
  endtask

  task automatic test_gaps();
    send_frame(4'd9, 4'd12, 8'hA5, 8'h3C, 2'b11, 3, 1'b0);
    wait_done("gap_wr");
    send_frame(4'd9, 4'd12, 8'h00, 8'h00, 2'b00, 3, 1'b0);
    wait_done("gap_rd");
  endtask

  task automatic test_rst_mid_shift();
    bit seen;
    send_frame(4'd3, 4'd7, 8'h00, 8'h00, 2'b00, 0, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (bus.sout_vld) seen = 1'b1;
      else begin @(posedge clk); #1; end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL midrst_start: sout_vld never rose, expected it within 20 cycles");
    end
    repeat (6) begin @(posedge clk); #1; end
    void'(exp_q.pop_back());
    void'(skip_q.pop_back());
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (bus.sout_vld !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL midrst_outputs: vld=%b busy=%b done=%b, expected 0 0 0",
               bus.sout_vld, bus.busy, bus.done);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.done !== 1'b0) begin
      errors++;
      $display("FAIL midrst_no_done: done=%b after reset, expected 0", bus.done);
    end
    send_frame(4'd7, 4'd3, 8'h00, 8'h00, 2'b00, 1, 1'b0);
    wait_done("midrst_rd");
  endtask

  task automatic test_ovf();
    send_frame(4'd3, 4'd5, 8'h00, 8'h00, 2'b00, 0, 1'b0);
    bus.sin = 1'b1;
    bus.sin_vld = 1'b1;
    repeat (10) begin @(posedge clk); #1; end
    bus.sin_vld = 1'b0;
    bus.sin = 1'b0;
    checks++;
    if (bus.ovf !== 1'b1) begin
      errors++;
      $display("FAIL ovf_set: ovf=%b, expected 1", bus.ovf);
    end
    wait_done("ovf_rd");
    send_frame(4'd7, 4'd9, 8'h00, 8'h00, 2'b00, 2, 1'b0);
    wait_done("ovf_next");
    checks++;
    if (bus.ovf !== 1'b1) begin
      errors++;
      $display("FAIL ovf_sticky: ovf=%b after a clean frame, expected 1", bus.ovf);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (bus.ovf !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clear: ovf=%b after reset, expected 0", bus.ovf);
    end
  endtask

`ifdef LVT_SCAN_PARITY_EN
  task automatic test_parity();
    send_frame(4'd2, 4'd0, 8'h77, 8'h00, 2'b01, 0, 1'b0);
    wait_done("par_wr_ok");
    checks++;
    if (bus.perr !== 1'b0) begin
      errors++;
      $display("FAIL perr_clean: perr=%b after good frame, expected 0", bus.perr);
    end
    send_frame(4'd2, 4'd0, 8'h99, 8'h00, 2'b01, 0, 1'b1);
    wait_done("par_wr_bad");
    checks++;
    if (bus.perr !== 1'b1) begin
      errors++;
      $display("FAIL perr_set: perr=%b after bad frame, expected 1", bus.perr);
    end
    send_frame(4'd2, 4'd2, 8'h00, 8'h00, 2'b00, 0, 1'b0);
    wait_done("par_rd1");
    send_frame(4'd2, 4'd0, 8'h44, 8'h00, 2'b01, 0, 1'b0);
    wait_done("par_wr_ok2");
    send_frame(4'd2, 4'd2, 8'h00, 8'h00, 2'b00, 0, 1'b0);
    wait_done("par_rd2");
    checks++;
    if (bus.perr !== 1'b1) begin
      errors++;
      $display("FAIL perr_sticky: perr=%b, expected 1", bus.perr);
    end
  endtask
`endif

  initial begin
    bus.sin = 1'b0;
    bus.sin_vld = 1'b0;
    for (int i = 0; i < D; i++) model[i] = '0;
    test_reset();
    test_basic();
    test_collision();
    test_gaps();
    test_rst_mid_shift();
    test_ovf();
`ifdef LVT_SCAN_PARITY_EN
    test_parity();
`endif
    repeat (3) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d readbacks outstanding, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
